uart_mult_byte_tx: RTL and testbench

- Multi-byte UART packet transmitter: latches dataA/dataB/dataC/dataD on a request and serialises them as one framed packet on uart_txd (8N1, LSB first).
- Transmit-side counterpart of uart_mult_byte_rx. Runs on clk_50M and echoes or reports the configuration fields to the host.
- Packet, 9 bytes, sent back-to-back:
  - 0xAA, 0x55 (header)
  - dataA
  - dataB[15:8], dataB[7:0]
  - dataC[15:8], dataC[7:0]
  - dataD
  - CHK = 8-bit sum, mod 256, of the 6 payload bytes.

---
 rtl/uart_pkt_pkg.sv | 37 +++
 rtl/uart_byte_tx.sv | 97 +++++++++
 rtl/uart_mult_byte_tx.sv | 122 ++++++++++++
 tb/tb_uart_mult_byte_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the multi-byte UART packet link (transmitter and receiver).
// Packet layout: HDR0, HDR1, A, B[15:8], B[7:0], C[15:8], C[7:0], D, CHK.
// CHK is the 8-bit wrap-around sum of the six payload bytes.
package uart_pkt_pkg;

    localparam logic [7:0]  HDR0        = 8'hAA;
    localparam logic [7:0]  HDR1        = 8'h55;
    localparam int unsigned PKT_LEN     = 9;
    localparam int unsigned PAYLOAD_LEN = 6;

    // Bit-level serialiser states (IDLE/START/DATA/STOP) plus packet-end DONE.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } uart_state_e;

    // Packet-level sequencer states.
    typedef enum logic [1:0] {
        PktIdle,
        PktSend,
        PktDone
    } pkt_state_e;

    // Payload is packed first byte in the MSBs; carries are discarded.
    function automatic logic [7:0] pkt_checksum(input logic [PAYLOAD_LEN*8-1:0] payload);
        logic [7:0] sum;
        sum = 8'h00;
        for (int unsigned i = 0; i < PAYLOAD_LEN; i++) begin
            sum = sum + payload[i*8 +: 8];
        end
        return sum;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser, LSB first, each bit held BPS_CNT cycles.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load data and begin a byte; honoured only while ready=1
//   data       byte to send
//   txd        registered serial output, idle high
//   ready      idle, or in the final cycle of the stop bit (allows gapless bytes)
//   last       final cycle of the stop bit
module uart_byte_tx
    import uart_pkt_pkg::*;
#(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready,
    output logic       last
);

    localparam int unsigned      CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

    uart_state_e      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;   // 0 start, 1..8 data, 9 stop
    logic [7:0]       data_q;
    logic             bit_end;

    assign bit_end = (bit_cnt == CNT_MAX);
    assign last    = (state == StStop) && bit_end;
    assign ready   = (state == StIdle) || last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            bit_cnt <= '0;
            bit_idx <= 4'd0;
            data_q  <= 8'h00;
            txd     <= 1'b1;
        end else if (start && ready) begin
            data_q  <= data;
            state   <= StStart;
            bit_cnt <= '0;
            bit_idx <= 4'd0;
            txd     <= 1'b0;
        end else begin
            case (state)
                StStart: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= 4'd1;
                        state   <= StData;
                        txd     <= data_q[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 4'd8) begin
                            state   <= StStop;
                            bit_idx <= 4'd9;
                            txd     <= 1'b1;
                        end else begin
                            // bit_idx k carries data bit k-1, so data bit k is next
                            bit_idx <= bit_idx + 4'd1;
                            txd     <= data_q[bit_idx[2:0]];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        state   <= StIdle;
                        bit_cnt <= '0;
                        bit_idx <= 4'd0;
                        txd     <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= StIdle;
                    bit_cnt <= '0;
                    bit_idx <= 4'd0;
                    txd     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART packet transmitter: latches four fields on send_req and sends
// AA 55 A B[15:8] B[7:0] C[15:8] C[7:0] D CHK back-to-back as 8N1 frames.
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   send_req           one-cycle request, ignored while tx_busy=1
//   dataA..dataD       payload fields (B and C sent MSB byte first)
//   uart_txd           serial line, idle high
//   tx_busy            high from acceptance until packet end
//   byte_idx           index of the byte on the line, 0..8
//   send_done          one-cycle pulse at packet end
module uart_mult_byte_tx
    import uart_pkt_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        send_req,
    input  logic [7:0]  dataA,
    input  logic [15:0] dataB,
    input  logic [15:0] dataC,
    input  logic [7:0]  dataD,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic [3:0]  byte_idx,
    output logic        send_done
);

    localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [3:0]  LAST_IDX = 4'(PKT_LEN - 1);

    pkt_state_e                 state;
    logic [7:0]                 shadow [PKT_LEN];
    logic [PAYLOAD_LEN*8-1:0]   payload;
    logic [3:0]                 next_idx;
    logic                       accept;
    logic                       byte_start;
    logic                       byte_ready;
    logic                       byte_last;
    logic [7:0]                 byte_data;

    assign payload  = {dataA, dataB, dataC, dataD};
    assign next_idx = byte_idx + 4'd1;
    // DONE counts as not busy, so a request there starts the next packet.
    assign accept   = send_req && (state != PktSend) && byte_ready;

    // Byte 0 is always the header constant, so the serialiser can load it on the
    // acceptance edge itself, before the shadow buffer holds anything.
    always_comb begin
        byte_start = accept;
        byte_data  = HDR0;
        if (!accept && (state == PktSend) && byte_last && (byte_idx != LAST_IDX)) begin
            byte_start = 1'b1;
            byte_data  = shadow[next_idx];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= PktIdle;
            tx_busy   <= 1'b0;
            byte_idx  <= 4'd0;
            send_done <= 1'b0;
            for (int unsigned i = 0; i < PKT_LEN; i++) begin
                shadow[i] <= 8'h00;
            end
        end else begin
            send_done <= 1'b0;
            case (state)
                PktIdle, PktDone: begin
                    state    <= PktIdle;
                    tx_busy  <= 1'b0;
                    byte_idx <= 4'd0;
                    if (accept) begin
                        state     <= PktSend;
                        tx_busy   <= 1'b1;
                        shadow[0] <= HDR0;
                        shadow[1] <= HDR1;
                        shadow[2] <= dataA;
                        shadow[3] <= dataB[15:8];
                        shadow[4] <= dataB[7:0];
                        shadow[5] <= dataC[15:8];
                        shadow[6] <= dataC[7:0];
                        shadow[7] <= dataD;
                        shadow[8] <= pkt_checksum(payload);
                    end
                end
                PktSend: begin
                    if (byte_last) begin
                        if (byte_idx == LAST_IDX) begin
                            state     <= PktDone;
                            send_done <= 1'b1;
                            tx_busy   <= 1'b0;
                            byte_idx  <= 4'd0;
                        end else begin
                            byte_idx <= next_idx;
                        end
                    end
                end
                default: begin
                    state    <= PktIdle;
                    tx_busy  <= 1'b0;
                    byte_idx <= 4'd0;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .start (byte_start),
        .data  (byte_data),
        .txd   (uart_txd),
        .ready (byte_ready),
        .last  (byte_last)
    );

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: checks every cycle of each packet against the
// expected 8N1 waveform, decodes each byte mid-bit, and checks packet-end timing.
module tb_uart_mult_byte_tx;

    // 50e6 / 2.4e6 = 20.83, truncated to 20 cycles per bit; keeps packets short.
    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned UART_BPS = 2_400_000;
    localparam int unsigned BPS      = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        send_req;
    logic [7:0]  dataA;
    logic [15:0] dataB;
    logic [15:0] dataC;
    logic [7:0]  dataD;
    logic        uart_txd;
    logic        tx_busy;
    logic [3:0]  byte_idx;
    logic        send_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] b;
        logic [15:0] c;
        logic [7:0]  d;
        logic [71:0] exp;
    } vec_t;

    vec_t vecs [5];

    uart_mult_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .send_req  (send_req),
        .dataA     (dataA),
        .dataB     (dataB),
        .dataC     (dataC),
        .dataD     (dataD),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .byte_idx  (byte_idx),
        .send_done (send_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_fields(input vec_t v);
        dataA = v.a;
        dataB = v.b;
        dataC = v.c;
        dataD = v.d;
    endtask

    // Entered #1 after a posedge with send_req already 1; returns in the DONE cycle
    // (chain=1, send_req left high) or after an idle stretch (chain=0).
    task automatic run_packet(input string name, input logic [71:0] exp,
                              input bit poke, input bit chg, input bit chain);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic       exp_bit;
        int         bad;
        int         cyc;
        bad = 0;
        cyc = 0;
        @(posedge sys_clk);
        #1;
        send_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_b = exp[71-8*k -: 8];
            got_b = 8'h00;
            for (int j = 0; j < 10; j++) begin
                exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[j-1];
                for (int c = 0; c < int'(BPS); c++) begin
                    if (uart_txd !== exp_bit || tx_busy !== 1'b1 ||
                        byte_idx !== 4'(k) || send_done !== 1'b0) begin
                        bad++;
                    end
                    if (j >= 1 && j <= 8 && c == int'(BPS / 2)) got_b[j-1] = uart_txd;
                    send_req = poke && (cyc % 300 == 150);
                    if (chg && cyc == 500) begin
                        dataA = ~dataA;
                        dataB = ~dataB;
                        dataC = dataC + 16'h1111;
                        dataD = dataD ^ 8'h3C;
                    end
                    cyc++;
                    @(posedge sys_clk);
                    #1;
                end
            end
            check($sformatf("%s byte%0d", name, k), 32'(got_b), 32'(exp_b));
        end
        send_req = 1'b0;
        check({name, " per-cycle waveform errors"}, bad, 0);
        check({name, " send_done in DONE"}, 32'(send_done), 1);
        check({name, " tx_busy in DONE"}, 32'(tx_busy), 0);
        check({name, " uart_txd in DONE"}, 32'(uart_txd), 1);
        check({name, " byte_idx in DONE"}, 32'(byte_idx), 0);
        if (chain) begin
            send_req = 1'b1;
        end else begin
            bad = 0;
            for (int c = 0; c < int'(3 * BPS); c++) begin
                @(posedge sys_clk);
                #1;
                if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || send_done !== 1'b0) bad++;
            end
            check({name, " idle after packet"}, bad, 0);
        end
    endtask

    initial begin
        int bad;
        vecs[0] = '{8'h08, 16'h1234, 16'hABCD, 8'h5A, 72'hAA_55_08_12_34_AB_CD_5A_20};
        vecs[1] = '{8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF, 72'hAA_55_FF_FF_FF_FF_FF_FF_FA};
        vecs[2] = '{8'h00, 16'h0000, 16'h0000, 8'h00, 72'hAA_55_00_00_00_00_00_00_00};
        vecs[3] = '{8'h01, 16'h0203, 16'h0405, 8'h06, 72'hAA_55_01_02_03_04_05_06_15};
        vecs[4] = '{8'h80, 16'h8080, 16'h8080, 8'h80, 72'hAA_55_80_80_80_80_80_80_00};

        sys_rst  = 1'b1;
        send_req = 1'b0;
        set_fields(vecs[2]);
        #2;
        check("reset uart_txd", 32'(uart_txd), 1);
        check("reset tx_busy", 32'(tx_busy), 0);
        check("reset byte_idx", 32'(byte_idx), 0);
        check("reset send_done", 32'(send_done), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        // Table-driven packets.
        for (int i = 0; i < 5; i++) begin
            set_fields(vecs[i]);
            send_req = 1'b1;
            run_packet($sformatf("vec%0d", i), vecs[i].exp, 1'b0, 1'b0, 1'b0);
        end

        // Requests during a packet are dropped, not queued.
        set_fields(vecs[0]);
        send_req = 1'b1;
        run_packet("poke", vecs[0].exp, 1'b1, 1'b0, 1'b0);

        // Field changes after acceptance do not reach the line.
        set_fields(vecs[3]);
        send_req = 1'b1;
        run_packet("fieldchg", vecs[3].exp, 1'b0, 1'b1, 1'b0);

        // Request in the DONE cycle: next packet after exactly one idle cycle.
        set_fields(vecs[0]);
        send_req = 1'b1;
        run_packet("chain1", vecs[0].exp, 1'b0, 1'b0, 1'b1);
        set_fields(vecs[1]);
        run_packet("chain2", vecs[1].exp, 1'b0, 1'b0, 1'b0);

        // Reset during byte 4 data bits aborts the packet immediately.
        set_fields(vecs[3]);
        send_req = 1'b1;
        @(posedge sys_clk);
        #1;
        send_req = 1'b0;
        repeat (4 * 10 * BPS + 3 * BPS) @(posedge sys_clk);
        #3;
        check("pre-reset byte_idx", 32'(byte_idx), 4);
        check("pre-reset tx_busy", 32'(tx_busy), 1);
        sys_rst = 1'b1;
        #1;
        check("midrst uart_txd", 32'(uart_txd), 1);
        check("midrst tx_busy", 32'(tx_busy), 0);
        check("midrst byte_idx", 32'(byte_idx), 0);
        check("midrst send_done", 32'(send_done), 0);
        bad = 0;
        repeat (5) begin
            @(posedge sys_clk);
            #1;
            if (send_done !== 1'b0 || uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        sys_rst = 1'b0;
        for (int c = 0; c < int'(12 * BPS); c++) begin
            @(posedge sys_clk);
            #1;
            if (send_done !== 1'b0 || uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("no resume after reset", bad, 0);
        set_fields(vecs[0]);
        send_req = 1'b1;
        run_packet("postrst", vecs[0].exp, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
